// File: rtl/alu_rr_sched_pkg.sv
// alu_sched_pkg: shared state encoding and ALU control codes for the round-robin ALU scheduler.
package alu_sched_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int ALU_CTRL_W = 3;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/alu_rr_sched_if.sv
// alu_rr_sched_if: requester handshakes plus ALU datapath signals for alu_rr_sched.
interface alu_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) ();
    import alu_sched_pkg::*;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*DATA_W-1:0]     req_a_i;
    logic [NUM_REQ*DATA_W-1:0]     req_b_i;
    logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl_i;
    logic [DATA_W-1:0]             alu_a_o;
    logic [DATA_W-1:0]             alu_b_o;
    logic [ALU_CTRL_W-1:0]         alu_ctrl_o;
    logic [DATA_W-1:0]             alu_result_i;
    logic                          alu_zero_i;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [NUM_REQ-1:0]            rsp_ready_i;
    logic [DATA_W-1:0]             rsp_result_o;
    logic                          rsp_zero_o;
    logic                          busy_o;
    modport master (
        output req_valid_i, req_a_i, req_b_i, req_ctrl_i, alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, rsp_valid_o, rsp_result_o, rsp_zero_o, busy_o
    );
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_ctrl_i, alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, rsp_valid_o, rsp_result_o, rsp_zero_o, busy_o
    );
endinterface

// File: rtl/alu_rr_sched_rr_pick.sv
// rr_pick: combinational rotating-priority picker; the requester just after last has top priority.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                gnt = N'(1) << ((int'(last) + i) % N);
                idx = IW'((int'(last) + i) % N);
            end
        end
    end
endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one ALU among NUM_REQ requesters in round-robin order,
// one operation outstanding at a time, with a fixed ALU latency.
module alu_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 2
) (
    input logic           clock,
    input logic           rst_i,
    alu_rr_sched_if.slave bus
);
    import alu_sched_pkg::*;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 4;
    state_t              state;
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       owner;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  gnt;
    logic [IW-1:0]       idx;
    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (bus.req_valid_i),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (idx)
    );
    assign bus.req_ready_o = (state == IDLE) ? gnt : '0;
    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            state            <= IDLE;
            last_grant       <= IW'(NUM_REQ - 1);
            owner            <= '0;
            cnt              <= '0;
            bus.alu_a_o      <= '0;
            bus.alu_b_o      <= '0;
            bus.alu_ctrl_o   <= '0;
            bus.rsp_result_o <= '0;
            bus.rsp_zero_o   <= 1'b0;
            bus.rsp_valid_o  <= '0;
            bus.busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    bus.alu_a_o    <= bus.req_a_i[int'(idx)*DATA_W +: DATA_W];
                    bus.alu_b_o    <= bus.req_b_i[int'(idx)*DATA_W +: DATA_W];
                    bus.alu_ctrl_o <= bus.req_ctrl_i[int'(idx)*ALU_CTRL_W +: ALU_CTRL_W];
                    owner          <= idx;
                    last_grant     <= idx;
                    cnt            <= CW'(ALU_LAT - 1);
                    bus.busy_o     <= 1'b1;
                    state          <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    bus.rsp_result_o <= bus.alu_result_i;
                    bus.rsp_zero_o   <= bus.alu_zero_i;
                    bus.rsp_valid_o  <= NUM_REQ'(1) << owner;
                    state            <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (bus.rsp_ready_i[owner]) begin
                    bus.rsp_valid_o <= '0;
                    bus.busy_o      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
